// File: rtl/din_debounce_pkg.sv
// -----------------------------------------------------------------------------
// din_debounce_pkg
//   Shared definitions for the din_debounce input conditioning block and its
//   synchroniser sub-module.
//
//   Contents:
//     state_t             - debounce FSM state encoding
//     DEF_SYNC_STAGES     - default synchroniser depth
//     DEF_STABLE_CYCLES   - default number of stable samples to accept a change
//     DEF_CNT_W           - default stability counter width
// -----------------------------------------------------------------------------
package din_debounce_pkg;

  // Debounce FSM states. The encoding is fixed so that external checkers and
  // waveform viewers can decode the state without reference to the RTL.
  typedef enum logic [1:0] {
    S_LOW    = 2'd0,  // settled low, q = 0
    S_PEND_H = 2'd1,  // saw a 1 at the synchroniser output, counting
    S_HIGH   = 2'd2,  // settled high, q = 1
    S_PEND_L = 2'd3   // saw a 0 at the synchroniser output, counting
  } state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_CNT_W         = 3;

endpackage : din_debounce_pkg

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
//   Multi-flop metastability synchroniser for a single asynchronous level.
//   Intended to be reused by any asynchronous input entering the clk domain.
//
//   Parameters:
//     SYNC_STAGES  - number of flops in the chain (minimum 2)
//
//   Ports:
//     clk      in   system clock, rising edge
//     rst      in   asynchronous active-high reset, clears every stage to 0
//     d_async  in   raw asynchronous level
//     d_sync   out  synchronised level (last stage of the chain)
// -----------------------------------------------------------------------------
module sync_chain
  import din_debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic d_sync
);

  // A single flop gives no metastability protection at all.
  if (SYNC_STAGES < 2) begin : g_bad_depth
    $error("sync_chain: SYNC_STAGES must be at least 2");
  end

  // stages[0] is the first flop to capture d_async; stages[SYNC_STAGES-1]
  // is the settled output.
  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d_async};
    end
  end

  assign d_sync = stages[SYNC_STAGES-1];

endmodule : sync_chain

// File: rtl/din_debounce.sv
// -----------------------------------------------------------------------------
// din_debounce
//   Conditions a raw, possibly bouncing asynchronous level into a clean
//   registered level for the clk domain. The level is first synchronised,
//   then any change must be seen for STABLE_CYCLES consecutive synchronised
//   samples before it is accepted. Accepted changes update q and emit a
//   single-cycle rise or fall strobe on the same edge.
//
//   Parameters:
//     SYNC_STAGES    - synchroniser depth (minimum 2)
//     STABLE_CYCLES  - consecutive samples needed to accept a change (min 2)
//     CNT_W          - stability counter width, 2**CNT_W > STABLE_CYCLES
//
//   Ports:
//     clk     in   system clock, all state updates on the rising edge
//     rst     in   asynchronous active-high reset
//     din     in   raw asynchronous input level
//     q       out  debounced registered level
//     rise    out  one-cycle pulse on the edge q goes 0->1
//     fall    out  one-cycle pulse on the edge q goes 1->0
//     toggle  out  inverts on every rise (only with DIN_DEBOUNCE_TOGGLE_EN)
//
//   Build option:
//     DIN_DEBOUNCE_TOGGLE_EN - adds the toggle output and its register,
//                              giving push-on/push-off behaviour.
//
//   Latency: with din held at a new level from edge N, q and the strobe
//   update on edge N + SYNC_STAGES + STABLE_CYCLES - 1.
// -----------------------------------------------------------------------------
module din_debounce
  import din_debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
`ifdef DIN_DEBOUNCE_TOGGLE_EN
  output logic fall,
  output logic toggle
`else
  output logic fall
`endif
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // ---------------------------------------------------------------------------
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("din_debounce: STABLE_CYCLES must be at least 2");
  end
  if ((2 ** CNT_W) <= STABLE_CYCLES) begin : g_bad_cnt_w
    $error("din_debounce: CNT_W too narrow for STABLE_CYCLES");
  end

  // The counter holds the number of consecutive new-level samples seen so
  // far; the sample that would make it STABLE_CYCLES is the accepting one,
  // so the compare value is one less than the required count.
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic s;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .d_async (din),
    .d_sync  (s)
  );

  // ---------------------------------------------------------------------------
  // Debounce FSM
  //   state   - current FSM state, kept as a named signal for probing
  //   cnt     - consecutive samples at the pending level
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  logic             q_nx;
  logic             rise_nx;
  logic             fall_nx;
  logic             accept_h;
  logic             accept_l;

  // State register, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LOW;
      cnt   <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      q     <= q_nx;
      rise  <= rise_nx;
      fall  <= fall_nx;
    end
  end

  // Acceptance happens on the sample that completes a run of STABLE_CYCLES
  // at the new level; shared by next-state and output logic.
  assign accept_h = (state == S_PEND_H) && s  && (cnt == CNT_LAST);
  assign accept_l = (state == S_PEND_L) && !s && (cnt == CNT_LAST);

  // Next-state logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_LOW: begin
        if (s) begin
          state_nx = S_PEND_H;
          cnt_nx   = CNT_ONE;
        end else begin
          cnt_nx   = '0;
        end
      end

      S_PEND_H: begin
        if (!s) begin
          // Level fell back before it was stable: glitch, drop it.
          state_nx = S_LOW;
          cnt_nx   = '0;
        end else if (accept_h) begin
          state_nx = S_HIGH;
          cnt_nx   = '0;
        end else begin
          cnt_nx   = cnt + CNT_ONE;
        end
      end

      S_HIGH: begin
        if (!s) begin
          state_nx = S_PEND_L;
          cnt_nx   = CNT_ONE;
        end else begin
          cnt_nx   = '0;
        end
      end

      S_PEND_L: begin
        if (s) begin
          state_nx = S_HIGH;
          cnt_nx   = '0;
        end else if (accept_l) begin
          state_nx = S_LOW;
          cnt_nx   = '0;
        end else begin
          cnt_nx   = cnt + CNT_ONE;
        end
      end

      // Unreachable with the 2-bit encoding, but an upset state register
      // must still land somewhere safe.
      default: begin
        state_nx = S_LOW;
        cnt_nx   = '0;
      end
    endcase
  end

  // Output logic: next values for the registered outputs. q follows the
  // settled state and only moves on an accepting sample.
  always_comb begin
    q_nx    = 1'b0;
    rise_nx = 1'b0;
    fall_nx = 1'b0;
    case (state)
      S_LOW: begin
        q_nx = 1'b0;
      end
      S_PEND_H: begin
        q_nx    = accept_h;
        rise_nx = accept_h;
      end
      S_HIGH: begin
        q_nx = 1'b1;
      end
      S_PEND_L: begin
        q_nx    = !accept_l;
        fall_nx = accept_l;
      end
      default: begin
        q_nx = 1'b0;
      end
    endcase
  end

`ifdef DIN_DEBOUNCE_TOGGLE_EN
  // ---------------------------------------------------------------------------
  // Toggle latch: flips on the same edge that registers a rise strobe.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle <= 1'b0;
    end else if (rise_nx) begin
      toggle <= !toggle;
    end
  end
`endif

endmodule : din_debounce
